// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode map, sequencer state encoding and instruction width
// shared by the semi_cpu control path.
package cpu_pkg;

  localparam int INSTR_W = 32;

  // Opcode field is instr[31:29]
  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_HALT = 3'b001;
  localparam logic [2:0] OP_R_LO = 3'b010;
  localparam logic [2:0] OP_R_HI = 3'b101;
  localparam logic [2:0] OP_I_LO = 3'b110;
  localparam logic [2:0] OP_I_HI = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_e;

  // True for opcodes that go through EXECUTE/WRITEBACK (R-type and I-type)
  function automatic logic is_exec_op(input logic [2:0] op);
    return ((op >= OP_R_LO) && (op <= OP_R_HI)) ||
           ((op >= OP_I_LO) && (op <= OP_I_HI));
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: instruction-memory fetch handshake (req/valid).
// master = sequencer side, slave = instruction memory side.
interface cpu_sequencer_if #(
  parameter int ADDR_W = 8
);

  logic                          imem_req;
  logic [ADDR_W-1:0]             imem_addr;
  logic [cpu_pkg::INSTR_W-1:0]   imem_rdata;
  logic                          imem_valid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );

endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control unit for semi_cpu.
// Fetches into IR, then sequences DECODE -> EXECUTE -> WRITEBACK.
// Optional build macro CPU_SEQ_PERF_CNT_EN adds a saturating 32-bit
// retired-instruction counter on output port 'retired'.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  cpu_sequencer_if.master     imem,
  output logic [INSTR_W-1:0]  ir,
  input  logic                dec_reg_write,
  output logic                alu_en,
  output logic                rf_we,
  output logic [ADDR_W-1:0]   pc,
  output logic                busy,
  output logic                halted
`ifdef CPU_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]         retired
`endif
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [2:0]          op;

  assign op = ir_q[INSTR_W-1 -: 3];

  // Next state, PC and IR; start is only honoured in IDLE and HALT
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem.imem_valid) begin
          ir_d    = imem.imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (op == OP_HALT) begin
          state_d = S_HALT;
        end else if (op == OP_NOP) begin
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_FETCH;
        end else if (is_exec_op(op)) begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        state_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_FETCH;
      end
      S_HALT: begin
        if (start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, PC and IR registers; reset wins over an in-flight fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  assign imem.imem_req  = (state_q == S_FETCH);
  assign imem.imem_addr = pc_q;
  assign ir             = ir_q;
  assign pc             = pc_q;
  assign alu_en         = (state_q == S_EXECUTE);
  assign rf_we          = (state_q == S_WRITEBACK) && dec_reg_write;
  assign busy           = (state_q == S_FETCH)   || (state_q == S_DECODE) ||
                          (state_q == S_EXECUTE) || (state_q == S_WRITEBACK);
  assign halted         = (state_q == S_HALT);

`ifdef CPU_SEQ_PERF_CNT_EN
  logic [31:0] retired_q, retired_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Count NOPs leaving DECODE and R/I-type leaving WRITEBACK; cleared on restart
  always_comb begin
    retired_d = retired_q;
    unique case (state_q)
      S_DECODE:    if (op == OP_NOP) retired_d = sat_inc(retired_q);
      S_WRITEBACK: retired_d = sat_inc(retired_q);
      S_HALT:      if (start) retired_d = '0;
      default:     ;
    endcase
  end

  // Retired-instruction counter register
  always_ff @(posedge clk) begin
    if (rst) retired_q <= '0;
    else     retired_q <= retired_d;
  end

  assign retired = retired_q;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: table-driven and randomized checks of cpu_sequencer.
// A second instance with ADDR_W=2 covers PC wrap.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, start2, dec_all;
  logic [31:0] ir, ir2;
  logic        dec_reg_write, alu_en, rf_we, busy, halted;
  logic        alu_en2, rf_we2, busy2, halted2;
  logic [7:0]  pc;
  logic [1:0]  pc2;
`ifdef CPU_SEQ_PERF_CNT_EN
  logic [31:0] retired, retired2;
`endif

  cpu_sequencer_if #(.ADDR_W(8)) bus ();
  cpu_sequencer_if #(.ADDR_W(2)) bus2 ();

  // Stand-in decoder: reg_write from ir[20], or forced high
  assign dec_reg_write = dec_all | ir[20];

  // Zero-wait memory for the wrap instance: every word is R-type tagged with its address
  assign bus2.imem_valid = bus2.imem_req;
  assign bus2.imem_rdata = 32'h4000_0000 | {30'd0, bus2.imem_addr};

  cpu_sequencer #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .imem(bus), .ir(ir),
    .dec_reg_write(dec_reg_write), .alu_en(alu_en), .rf_we(rf_we),
    .pc(pc), .busy(busy), .halted(halted)
`ifdef CPU_SEQ_PERF_CNT_EN
    , .retired(retired)
`endif
  );

  cpu_sequencer #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .imem(bus2), .ir(ir2),
    .dec_reg_write(1'b1), .alu_en(alu_en2), .rf_we(rf_we2),
    .pc(pc2), .busy(busy2), .halted(halted2)
`ifdef CPU_SEQ_PERF_CNT_EN
    , .retired(retired2)
`endif
  );

  typedef struct {
    logic        start;
    logic        req;
    logic        alu;
    logic        rf;
    logic        busy;
    logic        halt;
    logic [7:0]  pc;
    logic [31:0] ir;
  } vec_t;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] mem [256];
  int          waitc [256];
  int          wcnt = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0b expected %0b", name, $time, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Advance one clock; pulse inputs drop, memory responds to the current request
  task automatic cyc();
    @(posedge clk);
    #1;
    start  = 1'b0;
    start2 = 1'b0;
    rst    = 1'b0;
    if (bus.imem_req) begin
      if (wcnt >= waitc[bus.imem_addr]) begin
        bus.imem_valid = 1'b1;
        bus.imem_rdata = mem[bus.imem_addr];
        wcnt = 0;
      end else begin
        bus.imem_valid = 1'b0;
        bus.imem_rdata = $urandom;
        wcnt++;
      end
    end else begin
      bus.imem_valid = 1'b0;
      bus.imem_rdata = $urandom;
      wcnt = 0;
    end
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1;
    cyc();
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      mem[i]   = 32'h2000_0000;
      waitc[i] = 0;
    end
  endtask

  task automatic cmp_vec(input string tag, input vec_t e);
    chk1 ({tag, ".imem_req"}, bus.imem_req, e.req);
    chk1 ({tag, ".alu_en"},   alu_en,       e.alu);
    chk1 ({tag, ".rf_we"},    rf_we,        e.rf);
    chk1 ({tag, ".busy"},     busy,         e.busy);
    chk1 ({tag, ".halted"},   halted,       e.halt);
    chk32({tag, ".pc"},       32'(pc),      32'(e.pc));
    chk32({tag, ".imem_addr"}, 32'(bus.imem_addr), 32'(e.pc));
    chk32({tag, ".ir"},       ir,           e.ir);
  endtask

  vec_t        tbl [14];
  vec_t        q [$];
  int          len, nret, req_cnt;
  logic        any_alu, any_rf;
  logic [31:0] w, prev_ir;
  logic [2:0]  o;
  int          sel;

  localparam logic [31:0] W_R  = 32'h4A0C_4000;
  localparam logic [31:0] W_I  = 32'hC108_0005;
  localparam logic [31:0] W_H  = 32'h2000_0000;
  localparam logic [31:0] W_N  = 32'h0ABC_1234;

  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0; dec_all = 1'b1;
    bus.imem_valid = 1'b0;
    bus.imem_rdata = '0;
    clear_mem();

    // ---------------- reset state ----------------
    do_reset();
    chk1 ("reset.imem_req", bus.imem_req, 1'b0);
    chk32("reset.pc",       32'(pc),      32'd0);
    chk32("reset.ir",       ir,           32'd0);
    chk1 ("reset.alu_en",   alu_en,       1'b0);
    chk1 ("reset.rf_we",    rf_we,        1'b0);
    chk1 ("reset.busy",     busy,         1'b0);
    chk1 ("reset.halted",   halted,       1'b0);
`ifdef CPU_SEQ_PERF_CNT_EN
    chk32("reset.retired",  retired,      32'd0);
`endif

    // ---------------- zero-wait program R, I, HALT, then restart ----------------
    clear_mem();
    mem[0] = W_R; mem[1] = W_I; mem[2] = W_H;
    //          start req  alu  rf   busy halt pc     ir
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 32'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, W_R};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, W_R};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, W_R};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, W_R};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, W_I};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1, W_I};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, W_I};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2, W_I};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2, W_H};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2, W_H};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2, W_H};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, W_H};
    for (int k = 0; k < 14; k++) begin
      if (k > 0) cyc();
      cmp_vec($sformatf("prog0.c%0d", k), tbl[k]);
      start = tbl[k].start;
    end

    // ---------------- three memory wait cycles on an R-type ----------------
    clear_mem();
    mem[0] = 32'h5000_0001; waitc[0] = 3;
    do_reset();
    start = 1'b1;
    req_cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (k <= 7 && bus.imem_req) req_cnt++;
      if (k <= 4) begin
        chk1 ("wait.req_held",  bus.imem_req, 1'b1);
        chk32("wait.addr",      32'(bus.imem_addr), 32'd0);
        chk32("wait.ir_hold",   ir, 32'd0);
      end
      if (k == 5) begin
        chk32("wait.ir_capture", ir, 32'h5000_0001);
        chk1 ("wait.req_drop",   bus.imem_req, 1'b0);
      end
      if (k == 6) chk1("wait.alu_en", alu_en, 1'b1);
      if (k == 7) chk1("wait.rf_we",  rf_we,  1'b1);
      if (k == 8) begin
        chk32("wait.next_pc",  32'(pc), 32'd1);
        chk1 ("wait.next_req", bus.imem_req, 1'b1);
      end
    end
    chk32("wait.req_cycles", 32'(req_cnt), 32'd4);

    // ---------------- NOP then HALT ----------------
    clear_mem();
    mem[0] = W_N;
    do_reset();
    start = 1'b1;
    any_alu = 1'b0; any_rf = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      any_alu |= alu_en;
      any_rf  |= rf_we;
      if (k == 3) begin
        chk32("nop.pc_inc", 32'(pc), 32'd1);
        chk1 ("nop.refetch", bus.imem_req, 1'b1);
      end
      if (k == 4) chk1("nop.not_yet_halted", halted, 1'b0);
      if (k == 5) begin
        chk1 ("nop.halted", halted, 1'b1);
        chk32("nop.halt_pc", 32'(pc), 32'd1);
      end
    end
    chk1("nop.no_alu_en", any_alu, 1'b0);
    chk1("nop.no_rf_we",  any_rf,  1'b0);

    // ---------------- reset mid-FETCH with imem_valid high ----------------
    clear_mem();
    mem[0] = W_N; mem[1] = W_R;
    do_reset();
    start = 1'b1;
    cyc(); cyc(); cyc();
    chk32("rstfetch.pre_pc", 32'(pc), 32'd1);
    chk32("rstfetch.pre_ir", ir, W_N);
    bus.imem_valid = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    rst = 1'b1;
    cyc();
    chk1 ("rstfetch.req",    bus.imem_req, 1'b0);
    chk32("rstfetch.pc",     32'(pc), 32'd0);
    chk32("rstfetch.ir",     ir, 32'd0);
    chk1 ("rstfetch.busy",   busy, 1'b0);
    chk1 ("rstfetch.halted", halted, 1'b0);
    cyc();
    chk1 ("rstfetch.idle_stays", bus.imem_req, 1'b0);

    // ---------------- start held high while busy is ignored ----------------
    clear_mem();
    mem[0] = W_R; waitc[0] = 2;
    start = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      if (k <= 3) begin
        chk1 ("busystart.req", bus.imem_req, 1'b1);
        chk32("busystart.pc",  32'(pc), 32'd0);
      end
      if (k == 4) chk32("busystart.ir", ir, W_R);
      if (k == 5) chk1 ("busystart.alu_en", alu_en, 1'b1);
      if (k == 6) chk1 ("busystart.rf_we",  rf_we,  1'b1);
      if (k == 7) chk32("busystart.pc1", 32'(pc), 32'd1);
      if (k == 8) chk1 ("busystart.busy", busy, 1'b1);
      if (k == 9) chk1 ("busystart.halted", halted, 1'b1);
      if (k < 8) start = 1'b1;
    end

`ifdef CPU_SEQ_PERF_CNT_EN
    // ---------------- retired counter: 2 NOP + 3 R-type + HALT ----------------
    clear_mem();
    mem[0] = W_N; mem[1] = 32'h0000_0000;
    mem[2] = W_R; mem[3] = 32'h6000_0000; mem[4] = 32'hA000_0000;
    do_reset();
    start = 1'b1;
    for (int k = 0; k < 40 && !halted; k++) cyc();
    chk1 ("perf.halt_reached", halted, 1'b1);
    chk32("perf.retired", retired, 32'd5);
    start = 1'b1;
    cyc();
    chk32("perf.cleared", retired, 32'd0);
    chk1 ("perf.restart_busy", busy, 1'b1);
`endif

    // ---------------- ADDR_W=2 PC wrap ----------------
    do_reset();
    start2 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (k % 4 == 1) begin
        chk1 ("wrap.req",  bus2.imem_req, 1'b1);
        chk32("wrap.addr", 32'(bus2.imem_addr), 32'(((k - 1) / 4) % 4));
        chk32("wrap.pc",   32'(pc2), 32'(((k - 1) / 4) % 4));
      end
      if (k == 14) chk32("wrap.ir", ir2, 32'h4000_0003);
      if (k == 15) chk1 ("wrap.alu_en", alu_en2, 1'b1);
      if (k == 16) begin
        chk1("wrap.rf_we", rf_we2, 1'b1);
        chk1("wrap.busy", busy2, 1'b1);
        chk1("wrap.halted", halted2, 1'b0);
      end
`ifdef CPU_SEQ_PERF_CNT_EN
      if (k == 20) chk32("wrap.retired", retired2, 32'd4);
`endif
    end

    // ---------------- randomized programs vs. timeline model ----------------
    dec_all = 1'b0;
    for (int r = 0; r < 12; r++) begin
      clear_mem();
      len = $urandom_range(1, 15);
      for (int i = 0; i < len; i++) begin
        sel = $urandom_range(0, 2);
        if (sel == 0)      o = OP_NOP;
        else if (sel == 1) o = 3'($urandom_range(2, 5));
        else               o = 3'($urandom_range(6, 7));
        mem[i]   = {o, 29'($urandom)};
        waitc[i] = $urandom_range(0, 3);
      end
      mem[len]   = {OP_HALT, 29'($urandom)};
      waitc[len] = $urandom_range(0, 3);

      // Expand the program into its expected per-cycle timeline
      q.delete();
      prev_ir = 32'd0;
      nret = 0;
      q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0});
      for (int i = 0; i <= len; i++) begin
        w = mem[i];
        o = w[31:29];
        for (int k = 0; k <= waitc[i]; k++)
          q.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'(i), prev_ir});
        q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'(i), w});
        if (o == OP_HALT) begin
          q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'(i), w});
        end else if (o == OP_NOP) begin
          nret++;
        end else begin
          q.push_back('{1'b0, 1'b0, 1'b1, 1'b0,  1'b1, 1'b0, 8'(i), w});
          q.push_back('{1'b0, 1'b0, 1'b0, w[20], 1'b1, 1'b0, 8'(i), w});
          nret++;
        end
        prev_ir = w;
      end

      do_reset();
      for (int c = 0; c < q.size(); c++) begin
        if (c > 0) cyc();
        cmp_vec($sformatf("rand%0d.c%0d", r, c), q[c]);
        if (c == 0)         start = 1'b1;
        else if (q[c].busy) start = 1'($urandom_range(0, 1));
      end
`ifdef CPU_SEQ_PERF_CNT_EN
      chk32($sformatf("rand%0d.retired", r), retired, 32'(nret));
`endif
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
